// File: rtl/ahb_mailbox_mc.sv
// Multi-channel AHB mailbox: one word FIFO plus status, control and interrupt registers per channel.
// Define AHB_MAILBOX_ACK_EN to build the per-channel "consumer drained the FIFO" ack interrupt.

module ahb_mailbox_ch #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  wr_ctrl,
    input  logic                  wr_intr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [DATA_WIDTH-1:0] status,
    output logic [DATA_WIDTH-1:0] ctrl,
    output logic [DATA_WIDTH-1:0] intr_reg,
    output logic                  irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CW-1:0] count, cnt_nxt;
    logic ovf, udf, pend, en, ack;
    logic ovf_nxt, udf_nxt, pend_nxt, en_nxt, ack_nxt;
    logic empty, full, push_ok, pop_ok, flush;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign flush   = wr_ctrl & wdata[1];
    // push and pop are both judged against the count at the start of the cycle
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        rd_nxt   = rd_ptr;
        wr_nxt   = wr_ptr;
        cnt_nxt  = count + CW'(push_ok) - CW'(pop_ok);
        ovf_nxt  = ovf | (push & full);
        udf_nxt  = udf | (pop & empty);
        pend_nxt = pend;
        en_nxt   = wr_ctrl ? wdata[0] : en;
        if (push_ok)
            wr_nxt = wr_ptr + PW'(1);
        if (pop_ok)
            rd_nxt = rd_ptr + PW'(1);
        if (wr_intr && wdata[0])
            pend_nxt = 1'b0;
        if (push_ok)
            pend_nxt = 1'b1;
        if (flush) begin
            rd_nxt   = '0;
            wr_nxt   = '0;
            cnt_nxt  = '0;
            ovf_nxt  = 1'b0;
            udf_nxt  = 1'b0;
            pend_nxt = 1'b0;
        end
    end

`ifdef AHB_MAILBOX_ACK_EN
    always_comb begin
        ack_nxt = ack;
        if (wr_intr && wdata[1])
            ack_nxt = 1'b0;
        // only a pop that leaves the FIFO empty counts as a drain
        if (pop_ok && count == CW'(1) && !push_ok)
            ack_nxt = 1'b1;
        if (flush)
            ack_nxt = 1'b0;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            ack <= 1'b0;
        else
            ack <= ack_nxt;
    end
`else
    assign ack_nxt = 1'b0;
    assign ack     = 1'b0;
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
            pend   <= 1'b0;
            en     <= 1'b0;
            irq    <= 1'b0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_nxt;
            count  <= cnt_nxt;
            ovf    <= ovf_nxt;
            udf    <= udf_nxt;
            pend   <= pend_nxt;
            en     <= en_nxt;
            irq    <= (pend_nxt | ack_nxt) & en_nxt;
        end
    end

    always_ff @(posedge hclk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];
    assign status   = DATA_WIDTH'({8'(count), 3'b000, ack, udf, ovf, full, empty});
    assign ctrl     = DATA_WIDTH'(en);
    assign intr_reg = DATA_WIDTH'({ack, pend});
endmodule

module ahb_mailbox_mc #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [3:0]            hprot,
    input  logic [2:0]            hsize,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hburst,
    input  logic                  hwrite,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [1:0]            hresp,
    output logic                  hready,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic [NUM_CH-1:0]     mailbox_intr
);
    logic addr_vld, rd_vld;
    logic [3:0] rd_ch, wr_ch;
    logic [1:0] rd_reg, wr_reg;
    logic wr_pend;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [NUM_CH-1:0] push, pop, wr_ctrl, wr_intr;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] pop_w, status_w, ctrl_w, intr_w;
    logic unused_ok;

    assign hresp     = 2'b00;
    assign hready    = 1'b1;
    assign unused_ok = ^{hprot, hburst, hsize, haddr[ADDR_WIDTH-1:8], haddr[1:0]};

    assign addr_vld = hsel & htrans[1];
    assign rd_vld   = addr_vld & ~hwrite;
    assign rd_ch    = haddr[7:4];
    assign rd_reg   = haddr[3:2];

    // write address phase is held here so the register updates with hwdata one cycle later
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_pend <= 1'b0;
            wr_ch   <= '0;
            wr_reg  <= '0;
        end else begin
            wr_pend <= addr_vld & hwrite;
            if (addr_vld) begin
                wr_ch  <= haddr[7:4];
                wr_reg <= haddr[3:2];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign push[g]    = wr_pend && int'(wr_ch) == g && wr_reg == 2'd2;
        assign wr_ctrl[g] = wr_pend && int'(wr_ch) == g && wr_reg == 2'd1;
        assign wr_intr[g] = wr_pend && int'(wr_ch) == g && wr_reg == 2'd3;
        assign pop[g]     = rd_vld && int'(rd_ch) == g && rd_reg == 2'd2;

        ahb_mailbox_ch #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_ch (
            .hclk     (hclk),
            .hresetn  (hresetn),
            .push     (push[g]),
            .pop      (pop[g]),
            .wr_ctrl  (wr_ctrl[g]),
            .wr_intr  (wr_intr[g]),
            .wdata    (hwdata),
            .pop_data (pop_w[g]),
            .status   (status_w[g]),
            .ctrl     (ctrl_w[g]),
            .intr_reg (intr_w[g]),
            .irq      (mailbox_intr[g])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(rd_ch) == i) begin
                case (rd_reg)
                    2'd0: rd_mux = status_w[i];
                    2'd1: rd_mux = ctrl_w[i];
                    2'd2: rd_mux = pop_w[i];
                    2'd3: rd_mux = intr_w[i];
                endcase
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            hrdata <= '0;
        else if (rd_vld)
            hrdata <= rd_mux;
    end
endmodule

// File: tb/tb_ahb_mailbox_mc.sv
// Directed and random bus traffic against ahb_mailbox_mc, checked with a queue-based mailbox model.
module tb_ahb_mailbox_mc;
    localparam int AW = 32, DW = 32, NCH = 4, DEP = 4;
`ifdef AHB_MAILBOX_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic hclk = 1'b0, hresetn, hsel, hwrite;
    logic [AW-1:0] haddr;
    logic [3:0] hprot;
    logic [2:0] hsize, hburst;
    logic [1:0] htrans, hresp;
    logic [DW-1:0] hwdata, hrdata;
    logic hready;
    logic [NCH-1:0] mailbox_intr;

    ahb_mailbox_mc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH), .FIFO_DEPTH(DEP)) dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .hprot(hprot),
        .hsize(hsize), .htrans(htrans), .hburst(hburst), .hwrite(hwrite), .hwdata(hwdata),
        .hresp(hresp), .hready(hready), .hrdata(hrdata), .mailbox_intr(mailbox_intr)
    );

    always #5 hclk = ~hclk;

    int tests = 0, fails = 0;
    logic [31:0] mq [NCH][$];
    bit m_ovf [NCH], m_udf [NCH], m_pend [NCH], m_en [NCH], m_ack [NCH];
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NCH; i++) begin
            mq[i].delete();
            m_ovf[i] = 0; m_udf[i] = 0; m_pend[i] = 0; m_en[i] = 0; m_ack[i] = 0;
        end
    endfunction

    function automatic logic [31:0] m_status(int ch);
        int n = mq[ch].size();
        return {16'h0, 8'(n), 3'b000, m_ack[ch], m_udf[ch], m_ovf[ch], n == DEP, n == 0};
    endfunction

    function automatic void m_write(int ch, int rg, logic [31:0] d);
        if (ch >= NCH) return;
        case (rg)
            1: begin
                m_en[ch] = d[0];
                if (d[1]) begin
                    mq[ch].delete();
                    m_ovf[ch] = 0; m_udf[ch] = 0; m_pend[ch] = 0; m_ack[ch] = 0;
                end
            end
            2: if (mq[ch].size() == DEP) m_ovf[ch] = 1;
               else begin mq[ch].push_back(d); m_pend[ch] = 1; end
            3: begin
                if (d[0]) m_pend[ch] = 0;
                if (ACK && d[1]) m_ack[ch] = 0;
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] m_read(int ch, int rg);
        logic [31:0] r = 32'h0;
        if (ch >= NCH) return 32'h0;
        case (rg)
            0: r = m_status(ch);
            1: r = {31'h0, m_en[ch]};
            2: if (mq[ch].size() == 0) m_udf[ch] = 1;
               else begin
                   r = mq[ch].pop_front();
                   if (ACK && mq[ch].size() == 0) m_ack[ch] = 1;
               end
            3: r = {30'h0, m_ack[ch], m_pend[ch]};
            default: ;
        endcase
        return r;
    endfunction

    // write and read landing in the same cycle: both see the starting occupancy
    function automatic logic [31:0] m_push_pop(int ch, logic [31:0] d);
        int pre = mq[ch].size();
        logic [31:0] r = 32'h0;
        if (pre == 0) m_udf[ch] = 1;
        else r = mq[ch].pop_front();
        if (pre == DEP) m_ovf[ch] = 1;
        else begin mq[ch].push_back(d); m_pend[ch] = 1; end
        return r;
    endfunction

    function automatic logic [NCH-1:0] m_intr();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = (m_pend[i] | m_ack[i]) & m_en[i];
        return r;
    endfunction

    task automatic bus_idle();
        hsel = 0; htrans = 2'b00; hwrite = 0; haddr = $urandom;
    endtask

    task automatic bus_addr(input bit w, input int ch, input int rg);
        hsel = 1; htrans = 2'b10; hwrite = w; hsize = 3'b010;
        hprot = 4'($urandom); hburst = 3'($urandom);
        haddr = {24'h0, 4'(ch), 2'(rg), 2'b00};
    endtask

    task automatic bus_wr(input int ch, input int rg, input logic [31:0] d);
        bus_addr(1, ch, rg);
        @(negedge hclk);
        bus_idle(); hwdata = d;
        @(negedge hclk);
        m_write(ch, rg, d);
        hwdata = $urandom;
    endtask

    task automatic bus_rd(input string tag, input int ch, input int rg, output logic [31:0] v);
        logic [31:0] e;
        bus_addr(0, ch, rg);
        @(negedge hclk);
        bus_idle();
        v = hrdata;
        e = m_read(ch, rg);
        last_rd = e;
        check(tag, v, e);
    endtask

    task automatic b2b(input string tag, input int ch, input logic [31:0] d, output logic [31:0] v);
        logic [31:0] e;
        bus_addr(1, ch, 2);
        @(negedge hclk);
        bus_addr(0, ch, 2); hwdata = d;
        @(negedge hclk);
        bus_idle();
        v = hrdata;
        e = m_push_pop(ch, d);
        last_rd = e;
        check(tag, v, e);
    endtask

    task automatic chk_intr(input string tag);
        check(tag, 32'(mailbox_intr), 32'(m_intr()));
    endtask

    initial begin
        logic [31:0] v, d;
        int ch, rg;
        hresetn = 1; hwdata = 0; hprot = 0; hsize = 3'b010; hburst = 0;
        bus_idle();
        m_reset(); last_rd = 0;
        #1 hresetn = 0;
        repeat (2) @(negedge hclk);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_intr", 32'(mailbox_intr), 32'h0);
        check("rst_hresp", {30'h0, hresp}, 32'h0);
        hresetn = 1;
        @(negedge hclk);

        bus_rd("st0_reset", 0, 0, v);
        check("st0_reset_const", v, 32'h1);

        // doorbell on ch1
        bus_wr(1, 1, 32'h1);
        bus_wr(1, 2, 32'hA5A5A5A5);
        check("ch1_intr_set", 32'(mailbox_intr[1]), 32'h1);
        chk_intr("intr_after_push");
        bus_rd("ch1_pop", 1, 2, v);
        check("ch1_pop_const", v, 32'hA5A5A5A5);
        bus_wr(1, 3, 32'h1);
        chk_intr("ch1_intr_w1c");
        check("ch1_hold", hrdata, last_rd);

        // overflow / underflow on ch2
        for (int i = 0; i < 5; i++) bus_wr(2, 2, $urandom);
        bus_rd("ch2_full_st", 2, 0, v);
        check("ch2_full_const", v, 32'h406);
        for (int i = 0; i < 5; i++) bus_rd("ch2_pop", 2, 2, v);
        check("ch2_udf_data", v, 32'h0);
        bus_rd("ch2_udf_st", 2, 0, v);

        // same-cycle push and pop on a full ch0
        for (int i = 0; i < 4; i++) bus_wr(0, 2, $urandom);
        b2b("ch0_b2b_full", 0, $urandom, v);
        bus_rd("ch0_b2b_st", 0, 0, v);
        check("ch0_b2b_const", v, 32'h304);

        // flush of ch3 holding two words with ovf set
        for (int i = 0; i < 5; i++) bus_wr(3, 2, $urandom);
        bus_rd("ch3_pop", 3, 2, v);
        bus_rd("ch3_pop", 3, 2, v);
        bus_wr(3, 1, 32'h3);
        bus_rd("ch3_flush_st", 3, 0, v);
        check("ch3_flush_const", v, 32'h1);
        bus_rd("ch3_flush_intr", 3, 3, v);
        chk_intr("ch3_flush_irq");

        // drain ch0 with interrupts enabled
        bus_wr(0, 3, 32'h1);
        bus_wr(0, 1, 32'h1);
        for (int i = 0; i < 3; i++) bus_rd("ch0_drain", 0, 2, v);
        bus_rd("ch0_drain_st", 0, 0, v);
        chk_intr("ch0_drain_irq");
`ifdef AHB_MAILBOX_ACK_EN
        check("ch0_ack_bit", 32'(v[4]), 32'h1);
        check("ch0_ack_irq", 32'(mailbox_intr[0]), 32'h1);
`endif
        bus_wr(0, 3, 32'h2);
        chk_intr("ch0_ack_clr_irq");
        bus_rd("ch0_ack_clr_st", 0, 0, v);
        check("ch0_ack_clr_bit", 32'(v[4]), 32'h0);

        // BUSY and deselected transfers must not write
        hsel = 1; htrans = 2'b01; hwrite = 1; haddr = 32'h28;
        @(negedge hclk);
        hsel = 0; htrans = 2'b10; hwdata = $urandom;
        @(negedge hclk);
        bus_idle();
        @(negedge hclk);
        bus_rd("busy_no_push", 2, 0, v);

        // channel beyond NUM_CH
        bus_wr(5, 2, 32'hDEADBEEF);
        bus_rd("unmapped_data", 5, 2, v);
        bus_rd("unmapped_st", 5, 0, v);
        bus_rd("unmapped_reg_ch0", 0, 1, v);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            ch = $urandom_range(0, NCH);
            rg = $urandom_range(0, 3);
            d = $urandom;
            if (rg == 1 && $urandom_range(0, 7) != 0) d[1] = 1'b0;
            if ($urandom_range(0, 7) == 0 && ch < NCH) begin
                b2b("rnd_b2b", ch, d, v);
            end else if ($urandom_range(0, 1) == 1) begin
                bus_wr(ch, rg, d);
                check("rnd_hold", hrdata, last_rd);
            end else begin
                bus_rd("rnd_rd", ch, rg, v);
            end
            chk_intr("rnd_irq");
        end

        // reset during a write data phase
        bus_wr(1, 1, 32'h1);
        bus_addr(1, 1, 2);
        @(negedge hclk);
        bus_idle(); hwdata = 32'h12345678;
        #2 hresetn = 0;
        @(negedge hclk);
        hresetn = 1;
        m_reset(); last_rd = 0;
        check("midrst_hrdata", hrdata, 32'h0);
        chk_intr("midrst_irq");
        @(negedge hclk);
        bus_rd("midrst_st", 1, 0, v);
        check("midrst_st_const", v, 32'h1);
        bus_rd("midrst_ctrl", 1, 1, v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ahb_mailbox_mc.md
AHB_MAILBOX_MC -- requirements
Module: ahb_mailbox_mc

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AHB address width.
REQ-002 Parameter DATA_WIDTH, default 32, AHB data and message word width.
REQ-003 Parameter NUM_CH, default 4, channel count, range 1..16.
REQ-004 Parameter FIFO_DEPTH, default 4, words per channel FIFO, power of two, range 2..128.
REQ-005 hclk  input  1  single clock, all logic on its rising edge.
REQ-006 hresetn  input  1  asynchronous active-low reset.
REQ-007 hsel, haddr[ADDR_WIDTH], hprot[4], hsize[3], htrans[2], hburst[3], hwrite, hwdata[DATA_WIDTH]  input  AHB slave request; hprot and hburst are ignored.
REQ-008 hresp  output  2  always OKAY (2'b00).
REQ-009 hready  output  1  always 1, zero wait states.
REQ-010 hrdata  output  DATA_WIDTH  registered read data.
REQ-011 mailbox_intr  output  NUM_CH  per-channel doorbell interrupt, level, active-high.

Function
REQ-012 Valid transfer: hsel=1 and htrans[1]=1; IDLE and BUSY transfers have no effect.
REQ-013 Decode: channel = haddr[7:4], register = haddr[3:2]; channel >= NUM_CH reads 0, writes ignored.
REQ-014 Register 0x0 STATUS (RO): bit0 empty, bit1 full, bit2 ovf sticky, bit3 udf sticky, bit4 ack (macro only, else 0), bits[15:8] count.
REQ-015 Register 0x4 CTRL (RW): bit0 intr_en; bit1 flush, self-clearing, reads 0.
REQ-016 Register 0x8 DATA: write pushes hwdata; read pops the head word.
REQ-017 Register 0xC INTR (W1C): bit0 pending.
REQ-018 Write: address and channel/register latched in the address phase; the register is updated at the end of the data phase using hwdata.
REQ-019 Read: hrdata is loaded at the end of the address phase and held until the next valid read; a DATA pop takes effect in that same cycle.
REQ-020 Push when full: the word is dropped, ovf is set, count is unchanged.
REQ-021 Pop when empty: hrdata=0, udf is set, pointers are unchanged.
REQ-022 Push and pop on the same channel in the same cycle: both are evaluated against the pre-cycle count.
REQ-023 Same-cycle push and pop when full: the pop succeeds, the push is dropped with ovf, the count drops by 1.
REQ-024 Same-cycle push and pop when empty: the pop underflows, the push is accepted, count becomes 1.
REQ-025 Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-026 Each accepted push sets pending; if a W1C clear hits in the same cycle, set wins.
REQ-027 mailbox_intr[ch] = pending[ch] & intr_en[ch], driven from flops.
REQ-028 Flush clears pointers, count, ovf, udf, pending and ack in the cycle after the write; a push in the same cycle is discarded.
REQ-029 A read of 0x4 or 0xC returns the current register value; unmapped offsets read 0.

Reset
REQ-030 On hresetn low, hrdata=0, mailbox_intr=0, all FIFOs are empty, all sticky bits, pending and intr_en are 0, and the latched address phase is cleared.
REQ-031 If reset is asserted mid-transfer, the pending data-phase write is discarded.

Configuration
REQ-032 Macro AHB_MAILBOX_ACK_EN defined: a pop that empties a channel sets ack[ch], shown as STATUS bit4.
REQ-033 With AHB_MAILBOX_ACK_EN defined: ack is cleared by W1C to INTR bit1, and mailbox_intr[ch] = (pending | ack) & intr_en.
REQ-034 Macro AHB_MAILBOX_ACK_EN undefined: no ack logic is built, STATUS bit4 and INTR bit1 read 0, and writes to them are ignored.

Verification
REQ-035 Reset, then read ch0 STATUS -> 0x00000001 (empty, count 0); mailbox_intr=0.
REQ-036 Set ch1 intr_en, write 0xA5A5A5A5 to ch1 DATA -> mailbox_intr[1]=1 one cycle after the data phase; a read returns 0xA5A5A5A5; W1C INTR bit0 -> mailbox_intr[1]=0.
REQ-037 Push 5 words into ch2 with FIFO_DEPTH=4 -> STATUS=0x00000406 (full, ovf, count 4); 4 pops return words 1..4 in order; a 5th pop returns 0 with udf set.
REQ-038 Back-to-back write to ch0 DATA followed by read of ch0 DATA when full -> the pop returns the head word, ovf is set, count=3.
REQ-039 Write CTRL flush to ch3 holding 2 words with ovf set -> STATUS=0x00000001; pending=0.
REQ-040 With AHB_MAILBOX_ACK_EN and intr_en set, pop the last word of ch0 -> STATUS bit4=1 and mailbox_intr[0]=1; W1C INTR bit1 clears both.
